// File: rtl/bin2bcd_dd.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one operand bit per clock.
// Optional excess-3 coding of the result digits and a sticky overflow flag for too few digits.
module bin2bcd_dd #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    input  logic                  xs3,
    output logic                  ready,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  ovf
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] operand;
    logic [BW-1:0]    digits;
    logic [CW-1:0]    count;
    logic             mode;
    logic             sticky;

    logic [BW-1:0]    adjusted;
    logic [BW-1:0]    next_digits;
    logic [BW-1:0]    coded;
    logic             carry_out;

    // One dabble iteration; the bit leaving the top digit is lost and marks overflow.
    always_comb begin
        adjusted = digits;
        for (int i = 0; i < DIGITS; i++) begin
            if (digits[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = digits[4*i +: 4] + 4'd3;
            end
        end
        next_digits = {adjusted[BW-2:0], operand[WIDTH-1]};
        carry_out   = adjusted[BW-1];
        coded       = next_digits;
        if (mode) begin
            for (int i = 0; i < DIGITS; i++) begin
                coded[4*i +: 4] = next_digits[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            operand <= '0;
            digits  <= '0;
            count   <= '0;
            mode    <= 1'b0;
            sticky  <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            bcd     <= '0;
            ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        operand <= bin;
                        mode    <= xs3;
                        digits  <= '0;
                        sticky  <= 1'b0;
                        count   <= CW'(WIDTH);
                        ready   <= 1'b0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    operand <= operand << 1;
                    digits  <= next_digits;
                    sticky  <= sticky | carry_out;
                    count   <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bcd   <= coded;
                        ovf   <= sticky | carry_out;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_dd.sv
// Directed bench for bin2bcd_dd: a 3-digit and a 2-digit instance share clock, reset and operand.
// Expected digits come from a decimal-division reference, independent of the dabble algorithm.
module tb_bin2bcd_dd;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        start2;
    logic [7:0]  bin;
    logic        xs3;
    logic        ready;
    logic        done;
    logic [11:0] bcd;
    logic        ovf;
    logic        ready2;
    logic        done2;
    logic [7:0]  bcd2;
    logic        ovf2;

    int total;
    int bad;

    bin2bcd_dd #(.WIDTH(8), .DIGITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .xs3(xs3),
        .ready(ready), .done(done), .bcd(bcd), .ovf(ovf)
    );

    bin2bcd_dd #(.WIDTH(8), .DIGITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .bin(bin), .xs3(xs3),
        .ready(ready2), .done(done2), .bcd(bcd2), .ovf(ovf2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] refBcd(input int v, input logic mode, input int nd);
        logic [11:0] r;
        int          div;
        logic [3:0]  d;
        r   = '0;
        div = 1;
        for (int i = 0; i < nd; i++) begin
            d = 4'((v / div) % 10);
            if (mode) d = d + 4'd3;
            r[4*i +: 4] = d;
            div = div * 10;
        end
        return r;
    endfunction

    // Waits for ready, captures one operand, scrambles the inputs and returns the latency to done.
    task automatic applyStimulus(input logic [7:0] value, input logic mode, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        bin   = value;
        xs3   = mode;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        bin   = ~value;
        xs3   = ~mode;
        lat   = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic applyNarrow(input logic [7:0] value, output int lat);
        bin    = value;
        xs3    = 1'b0;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        bin    = 8'h00;
        lat    = 0;
        while (!done2 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int pulses;
        int cyc;
        int stamps[$];

        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        start2 = 1'b0;
        bin    = '0;
        xs3    = 1'b0;

        #12;
        checkOutput("rst_ready", ready, 1'b1);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_bcd", bcd, 12'h000);
        checkOutput("rst_ovf", ovf, 1'b0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(8'd255, 1'b0, lat);
        checkOutput("lat_255", lat, 8);
        checkOutput("bcd_255", bcd, 12'h255);
        checkOutput("ovf_255", ovf, 1'b0);
        checkOutput("ready_in_done", ready, 1'b0);
        @(posedge clk); #1;
        checkOutput("done_pulse_end", done, 1'b0);
        checkOutput("ready_after", ready, 1'b1);
        checkOutput("bcd_hold_idle", bcd, 12'h255);

        applyStimulus(8'd0, 1'b0, lat);
        checkOutput("bcd_0_plain", bcd, 12'h000);
        applyStimulus(8'd0, 1'b1, lat);
        checkOutput("bcd_0_xs3", bcd, 12'h333);
        applyStimulus(8'd9, 1'b1, lat);
        checkOutput("bcd_9_xs3", bcd, 12'h33C);
        @(posedge clk); #1;

        // A start pulse mid-conversion must neither queue nor disturb the result.
        bin    = 8'd42;
        xs3    = 1'b0;
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        bin    = 8'd77;
        pulses = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (i == 3) start = 1'b1;
            if (i == 4) start = 1'b0;
            if (i == 5) checkOutput("bcd_hold_shift", bcd, 12'h33C);
            if (done) pulses++;
        end
        checkOutput("ignored_pulses", pulses, 1);
        checkOutput("ignored_bcd", bcd, 12'h042);

        // Reset three cycles into a conversion.
        bin   = 8'd123;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("abort_ready", ready, 1'b1);
        checkOutput("abort_bcd", bcd, 12'h000);
        checkOutput("abort_done", done, 1'b0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst_n = 1'b1;
            if (done) pulses++;
        end
        checkOutput("abort_no_done", pulses, 0);
        applyStimulus(8'd100, 1'b0, lat);
        checkOutput("after_abort_lat", lat, 8);
        checkOutput("after_abort_bcd", bcd, 12'h100);

        applyNarrow(8'd200, lat);
        checkOutput("n2_200_lat", lat, 8);
        checkOutput("n2_200_bcd", bcd2, 8'h00);
        checkOutput("n2_200_ovf", ovf2, 1'b1);
        @(posedge clk); #1;
        applyNarrow(8'd99, lat);
        checkOutput("n2_99_bcd", bcd2, 8'h99);
        checkOutput("n2_99_ovf", ovf2, 1'b0);
        @(posedge clk); #1;
        applyNarrow(8'd255, lat);
        checkOutput("n2_255_bcd", bcd2, 8'h55);
        checkOutput("n2_255_ovf", ovf2, 1'b1);
        @(posedge clk); #1;

        // Start held high: back-to-back conversions at the full rate.
        bin   = 8'd57;
        xs3   = 1'b0;
        start = 1'b1;
        cyc   = 0;
        for (int i = 0; i < 45; i++) begin
            @(posedge clk); #1;
            cyc++;
            if (done) stamps.push_back(cyc);
        end
        start = 1'b0;
        checkOutput("held_count", stamps.size() >= 3, 1'b1);
        if (stamps.size() >= 3) begin
            checkOutput("held_first", stamps[0], 9);
            checkOutput("held_gap1", stamps[1] - stamps[0], 10);
            checkOutput("held_gap2", stamps[2] - stamps[1], 10);
        end
        checkOutput("held_bcd", bcd, 12'h057);

        for (int v = 0; v < 256; v++) begin
            for (int m = 0; m < 2; m++) begin
                applyStimulus(8'(v), 1'(m), lat);
                checkOutput($sformatf("exh_%0d_%0d", v, m), bcd, refBcd(v, 1'(m), 3));
                checkOutput($sformatf("exh_ovf_%0d", v), ovf, 1'b0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin2bcd_dd.md
BIN2BCD_DD -- requirements
Module: bin2bcd_dd

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning binary input width (legal range 4..32).
REQ-002 The module SHALL have parameter DIGITS, default 3, meaning the number of BCD output digits (legal range 1..10).
REQ-003 The module SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-005 The module SHALL have port start, input, 1 bit, meaning a conversion request, accepted only when ready=1.
REQ-006 The module SHALL have port bin, input, WIDTH bits, meaning the unsigned binary operand, sampled with start.
REQ-007 The module SHALL have port xs3, input, 1 bit, meaning the mode select sampled with start (0 = plain BCD, 1 = excess-3 coded digits).
REQ-008 The module SHALL have port ready, output, 1 bit, meaning the block is idle and will accept start.
REQ-009 The module SHALL have port done, output, 1 bit, meaning a one-cycle pulse that marks the cycle in which a new result is valid.
REQ-010 The module SHALL have port bcd, output, 4*DIGITS bits, meaning the result; digit 0 is in [3:0] and is least significant.
REQ-011 The module SHALL have port ovf, output, 1 bit, meaning the result was truncated because DIGITS is too few; it is valid with bcd.

Function
REQ-012 The converter SHALL use shift-and-add-3 (double dabble) with one bit per cycle, as a 3-state FSM: IDLE, SHIFT, DONE.
REQ-013 In IDLE with start=1 at edge N, the block SHALL capture bin and xs3, clear the working digit register and the overflow flag, load the bit counter with WIDTH, enter SHIFT, and drive ready=0 from edge N.
REQ-014 In SHIFT, each edge N+1..N+WIDTH SHALL perform one iteration: +3 on every working digit >=5, then a 1-bit left shift of {digits, operand} with the operand MSB entering digit 0.
REQ-015 A 1 shifted out of the MSB of the top digit during any iteration SHALL set the sticky overflow flag.
REQ-016 At edge N+WIDTH the block SHALL enter DONE and SHALL load bcd with the final digits (each digit +3, mod 16, when captured xs3=1) and load ovf.
REQ-017 done SHALL be 1 only in the cycle after edge N+WIDTH; at edge N+WIDTH+1 the FSM SHALL return to IDLE with done=0 and ready=1.
REQ-018 The latency from the capture edge to done high SHALL be exactly WIDTH cycles; the throughput SHALL be one conversion per WIDTH+2 cycles.
REQ-019 bcd and ovf SHALL hold their values from one done until the next done, and SHALL NOT change during SHIFT.
REQ-020 start while ready=0 (SHIFT or DONE) SHALL be ignored with no queuing; start held high SHALL be accepted at the first edge with ready=1.
REQ-021 A changing bin or xs3 after capture SHALL NOT affect the conversion in progress.
REQ-022 On overflow, bcd SHALL equal bin mod 10^DIGITS (before excess-3 adjustment).

Reset
REQ-023 When rst_n=0, the block SHALL immediately and asynchronously go to IDLE with ready=1, done=0, ovf=0, bcd=0, and clear the working registers and counter.
REQ-024 Reset asserted mid-conversion SHALL abort the conversion without a done pulse; the first start after rst_n rises SHALL be accepted normally.

Verification
REQ-025 The bench SHALL cover (WIDTH=8, DIGITS=3): bin=255, xs3=0, start at edge N -> done=1 in the cycle after edge N+8, bcd=12'h255, ovf=0, ready=1 after edge N+9.
REQ-026 The bench SHALL cover: bin=9, xs3=1 -> bcd=12'h33C; bin=0, xs3=1 -> bcd=12'h333; bin=0, xs3=0 -> bcd=12'h000.
REQ-027 The bench SHALL cover: start pulsed in SHIFT with a different bin -> ignored; only the first result appears and exactly one done pulse occurs.
REQ-028 The bench SHALL cover: rst_n low 3 cycles after capture -> ready=1, bcd=0, no done; next start with bin=100 -> bcd=12'h100.
REQ-029 The bench SHALL cover (WIDTH=8, DIGITS=2): bin=200 -> ovf=1, bcd=8'h00; bin=99 -> ovf=0, bcd=8'h99.
REQ-030 The bench SHALL cover: start held high continuously with a fixed bin -> done pulses every 10 cycles (WIDTH=8); all 256 inputs checked against a reference model in both modes.
